// File: rtl/scan_seq_ctl.sv
// scan_seq_ctl: on-chip scan pattern sequencer.
//
// Streams load data into NCHAIN scan chains, sequences shift/capture phases
// and compares unloaded scan-out against expected/mask data. Unload of
// pattern p overlaps the load of pattern p+1, so a run of npat patterns
// takes npat+1 shift passes; the last pass is unload-only.
//
// Ports:
//   clk_i, srst_i          clock, synchronous active-high reset
//   start_i, abort_i       begin sequence (pulse) / terminate sequence
//   npat_i                 pattern count, sampled on start
//   din_vld_i/din_rdy_o    stream beat handshake
//   din_si_i/exp_i/msk_i   scan-in, expected scan-out, don't-care mask
//   so_i / si_o            chain scan-outs / registered chain scan-ins
//   se_o, sclk_en_o        scan enable, one shift per sclk_en pulse
//   cap_en_o               capture clock enable
//   busy_o, done_o         in progress / one-cycle completion pulse
//   aborted_o              last sequence ended by abort
//   fail_cnt_o             saturating miscompare-cycle count
//   ff_vld_o/pat_o/idx_o   first failure location
module scan_seq_ctl #(
    parameter int NCHAIN = 4,
    parameter int CHLEN  = 32,
    parameter int NCAP   = 1,
    parameter int PATW   = 12,
    parameter int FCW    = 16,
    localparam int IDXW  = (CHLEN > 1) ? $clog2(CHLEN) : 1
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [PATW-1:0]   npat_i,
    input  logic              din_vld_i,
    output logic              din_rdy_o,
    input  logic [NCHAIN-1:0] din_si_i,
    input  logic [NCHAIN-1:0] din_exp_i,
    input  logic [NCHAIN-1:0] din_msk_i,
    input  logic [NCHAIN-1:0] so_i,
    output logic [NCHAIN-1:0] si_o,
    output logic              se_o,
    output logic              sclk_en_o,
    output logic              cap_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [FCW-1:0]    fail_cnt_o,
    output logic              ff_vld_o,
    output logic [PATW-1:0]   ff_pat_o,
    output logic [IDXW-1:0]   ff_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_SETUP, S_CAP, S_HOLD, S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [PATW-1:0]   npat_q, pass_q;
    logic [IDXW-1:0]   idx_q;
    logic [1:0]        capcnt_q;
    logic [NCHAIN-1:0] si_q;
    logic              done_q, aborted_q, ff_vld_q;
    logic [FCW-1:0]    fail_cnt_q;
    logic [PATW-1:0]   ff_pat_q;
    logic [IDXW-1:0]   ff_idx_q;

    logic              busy, start_take, abort_take, beat, last_beat, final_pass;
    logic [NCHAIN-1:0] mism;

    assign busy       = (state_q == S_SHIFT) || (state_q == S_SETUP) ||
                        (state_q == S_CAP)   || (state_q == S_HOLD);
    assign start_take = start_i && !busy;
    // abort wins over the in-cycle beat and over any state change
    assign abort_take = abort_i && busy;
    assign beat       = (state_q == S_SHIFT) && din_vld_i && !abort_i;
    assign last_beat  = beat && (idx_q == IDXW'(CHLEN - 1));
    // pass == npat is the trailing unload-only pass
    assign final_pass = (pass_q == npat_q);
    assign mism       = (so_i ^ din_exp_i) & ~din_msk_i;

    // state register
    always_ff @(posedge clk_i) begin
        if (srst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start_i) state_d = (npat_i == '0) ? S_FIN : S_SHIFT;
            end
            S_SHIFT: if (last_beat) state_d = final_pass ? S_FIN : S_SETUP;
            S_SETUP: state_d = S_CAP;
            S_CAP:   if (capcnt_q == 2'(NCAP - 1)) state_d = S_HOLD;
            S_HOLD:  state_d = S_SHIFT;
            default: state_d = S_IDLE;
        endcase
        if (abort_take) state_d = S_IDLE;
    end

    // outputs
    always_comb begin
        se_o      = (state_q == S_SHIFT);
        din_rdy_o = (state_q == S_SHIFT) && !abort_i;
        sclk_en_o = beat;
        cap_en_o  = (state_q == S_CAP);
        busy_o    = busy;
    end

    // datapath and result registers
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            npat_q     <= '0;
            pass_q     <= '0;
            idx_q      <= '0;
            capcnt_q   <= '0;
            si_q       <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            fail_cnt_q <= '0;
            ff_vld_q   <= 1'b0;
            ff_pat_q   <= '0;
            ff_idx_q   <= '0;
        end else begin
            // done is raised for the FIN cycle or the cycle after an abort
            done_q   <= (state_d == S_FIN) || abort_take;
            capcnt_q <= (state_q == S_CAP) ? capcnt_q + 2'd1 : 2'd0;
            if (state_q == S_HOLD) pass_q <= pass_q + 1'b1;
            if (start_take) begin
                npat_q     <= npat_i;
                pass_q     <= '0;
                idx_q      <= '0;
                si_q       <= '0;
                aborted_q  <= 1'b0;
                fail_cnt_q <= '0;
                ff_vld_q   <= 1'b0;
                ff_pat_q   <= '0;
                ff_idx_q   <= '0;
            end
            if (abort_take) aborted_q <= 1'b1;
            if (beat) begin
                si_q  <= final_pass ? '0 : din_si_i;
                idx_q <= last_beat ? '0 : idx_q + 1'b1;
                // pass 0 unloads nothing meaningful, so no compare there
                if ((pass_q != '0) && (mism != '0)) begin
                    if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + 1'b1;
                    if (!ff_vld_q) begin
                        ff_vld_q <= 1'b1;
                        ff_pat_q <= pass_q - 1'b1;
                        ff_idx_q <= idx_q;
                    end
                end
            end
        end
    end

    assign si_o       = si_q;
    assign done_o     = done_q;
    assign aborted_o  = aborted_q;
    assign fail_cnt_o = fail_cnt_q;
    assign ff_vld_o   = ff_vld_q;
    assign ff_pat_o   = ff_pat_q;
    assign ff_idx_o   = ff_idx_q;

endmodule

// File: tb/tb_scan_seq_ctl.sv
// Directed bench for scan_seq_ctl with an external identity-capture chain
// model and a scoreboard queue of expected si values.
module tb_scan_seq_ctl;
    localparam int NCHAIN = 2;
    localparam int CHLEN  = 4;
    localparam int NCAP   = 1;
    localparam int PATW   = 12;
    localparam int FCW    = 16;
    localparam int IDXW   = 2;

    logic              clk;
    logic              srst_i, start_i, abort_i, din_vld_i, din_rdy_o;
    logic [PATW-1:0]   npat_i;
    logic [NCHAIN-1:0] din_si_i, din_exp_i, din_msk_i, so_i, si_o;
    logic              se_o, sclk_en_o, cap_en_o, busy_o, done_o, aborted_o;
    logic [FCW-1:0]    fail_cnt_o;
    logic              ff_vld_o;
    logic [PATW-1:0]   ff_pat_o;
    logic [IDXW-1:0]   ff_idx_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    scan_seq_ctl #(.NCHAIN(NCHAIN), .CHLEN(CHLEN), .NCAP(NCAP), .PATW(PATW), .FCW(FCW)) dut (
        .clk_i(clk), .srst_i(srst_i), .start_i(start_i), .abort_i(abort_i),
        .npat_i(npat_i), .din_vld_i(din_vld_i), .din_rdy_o(din_rdy_o),
        .din_si_i(din_si_i), .din_exp_i(din_exp_i), .din_msk_i(din_msk_i),
        .so_i(so_i), .si_o(si_o), .se_o(se_o), .sclk_en_o(sclk_en_o),
        .cap_en_o(cap_en_o), .busy_o(busy_o), .done_o(done_o),
        .aborted_o(aborted_o), .fail_cnt_o(fail_cnt_o), .ff_vld_o(ff_vld_o),
        .ff_pat_o(ff_pat_o), .ff_idx_o(ff_idx_o)
    );

    // external chains: shift on sclk_en, capture leaves contents unchanged
    logic [NCHAIN-1:0][CHLEN-1:0] chn;
    logic [NCHAIN-1:0]            flip;
    always_ff @(posedge clk) begin
        if (srst_i) chn <= '0;
        else if (sclk_en_o)
            for (int k = 0; k < NCHAIN; k++) chn[k] <= {chn[k][CHLEN-2:0], si_o[k]};
    end
    always_comb begin
        so_i = '0;
        for (int k = 0; k < NCHAIN; k++) so_i[k] = chn[k][CHLEN-1] ^ flip[k];
    end

    logic [39:0] outs;
    assign outs = {din_rdy_o, si_o, se_o, sclk_en_o, cap_en_o, busy_o, done_o,
                   aborted_o, fail_cnt_o, ff_vld_o, ff_pat_o, ff_idx_o};

    int nvec = 0, nfail = 0;
    logic [NCHAIN-1:0]            siq[$];
    logic [NCHAIN-1:0]            cur_si;
    logic [NCHAIN-1:0][CHLEN-1:0] ref_ch;
    logic [63:0]                  pats;

    logic [31:0] se_h, sclk_h, cap_h, busy_h;
    int          done_c, done_n;
    bit          rdy_seen;
    logic [39:0] snap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_seq(input int npat, input bit do_rst, input int ncyc,
                           input int stall_at, input int flip_b, input int msk_b,
                           input int abort_cyc, input int srst_cyc, input int snap_cyc);
        logic [NCHAIN-1:0] ex;
        int  b;
        bit  bt;
        b = 0;
        if (do_rst) begin
            srst_i = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            srst_i = 1'b0;
            cur_si = '0;
            ref_ch = '0;
        end
        siq.delete();
        se_h = '0; sclk_h = '0; cap_h = '0; busy_h = '0;
        done_c = -1; done_n = 0; rdy_seen = 0; snap = '0;
        for (int c = 0; c < ncyc; c++) begin
            start_i   = (c == 0);
            npat_i    = PATW'(npat);
            abort_i   = (c == abort_cyc);
            srst_i    = (c == srst_cyc);
            din_vld_i = !(c >= stall_at && c < stall_at + 3);
            din_si_i  = pats[2*b +: 2];
            for (int k = 0; k < NCHAIN; k++) ex[k] = ref_ch[k][CHLEN-1];
            din_exp_i = ex;
            din_msk_i = (b == msk_b)  ? 2'b10 : 2'b00;
            flip      = (b == flip_b) ? 2'b10 : 2'b00;
            #1;
            if (siq.size() > 0) cur_si = siq.pop_front();
            chk("si", 64'(si_o), 64'(cur_si));
            se_h[c]   = se_o;
            sclk_h[c] = sclk_en_o;
            cap_h[c]  = cap_en_o;
            busy_h[c] = busy_o;
            if (din_rdy_o) rdy_seen = 1;
            if (done_o) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (c == snap_cyc) snap = outs;
            bt = din_rdy_o && din_vld_i && !srst_i;
            if (c == 0) siq.push_back('0);      // start clears si
            if (bt) begin
                for (int k = 0; k < NCHAIN; k++)
                    ref_ch[k] = {ref_ch[k][CHLEN-2:0], cur_si[k]};
                siq.push_back((b / CHLEN == npat) ? '0 : din_si_i);
                b++;
            end
            if (srst_i) begin
                siq.delete();
                siq.push_back('0);
                ref_ch = '0;
            end
            @(posedge clk);
            #1;
        end
        start_i = 0; abort_i = 0; srst_i = 0; din_vld_i = 0; flip = '0;
        din_msk_i = '0;
    endtask

    initial begin
        pats = 64'h9C36_B4E1_5A3C_D287;
        srst_i = 1; start_i = 0; abort_i = 0; npat_i = '0; din_vld_i = 0;
        din_si_i = '0; din_exp_i = '0; din_msk_i = '0; flip = '0;
        cur_si = '0; ref_ch = '0;
        repeat (2) @(posedge clk);
        #1;
        srst_i = 0;
        #1;
        chk("reset_outs", 64'(outs), 64'h0);

        // clean run, npat=1
        run_seq(1, 1, 16, -10, -1, -1, -1, -1, -1);
        chk("s1_se", se_h, 32'h0F1E);
        chk("s1_sclk", sclk_h, 32'h0F1E);
        chk("s1_cap", cap_h, 32'h0040);
        chk("s1_busy", busy_h, 32'h0FFE);
        chk("s1_done_cyc", done_c, 12);
        chk("s1_done_n", done_n, 1);
        chk("s1_fail", fail_cnt_o, 0);
        chk("s1_ffvld", ff_vld_o, 0);

        // chain1 flipped at pass-1 beat 2
        run_seq(1, 1, 16, -10, CHLEN + 2, -1, -1, -1, -1);
        chk("s2_fail", fail_cnt_o, 1);
        chk("s2_ffvld", ff_vld_o, 1);
        chk("s2_ffpat", ff_pat_o, 0);
        chk("s2_ffidx", ff_idx_o, 2);
        chk("s2_done_cyc", done_c, 12);

        // same flip, masked
        run_seq(1, 1, 16, -10, CHLEN + 2, CHLEN + 2, -1, -1, -1);
        chk("s3_fail", fail_cnt_o, 0);
        chk("s3_ffvld", ff_vld_o, 0);

        // 3-cycle stall in pass 0
        run_seq(1, 1, 18, 3, -1, -1, -1, -1, -1);
        chk("s4_se", se_h, 32'h78FE);
        chk("s4_sclk", sclk_h, 32'h78C6);
        chk("s4_cap", cap_h, 32'h0200);
        chk("s4_done_cyc", done_c, 15);
        chk("s4_fail", fail_cnt_o, 0);
        chk("s4_ffvld", ff_vld_o, 0);

        // abort during CAP
        run_seq(1, 1, 10, -10, -1, -1, 6, -1, 7);
        chk("s5_done_cyc", done_c, 7);
        chk("s5_done_n", done_n, 1);
        chk("s5_se", se_h, 32'h001E);
        chk("s5_cap", cap_h, 32'h0040);
        chk("s5_busy", busy_h, 32'h007E);
        chk("s5_snap_ctl", 64'({snap[39], snap[36:34]}), 64'h0);
        chk("s5_aborted", aborted_o, 1);

        // npat=0 right after the abort: immediate done, aborted cleared
        run_seq(0, 0, 4, -10, -1, -1, -1, -1, -1);
        chk("s6_done_cyc", done_c, 1);
        chk("s6_done_n", done_n, 1);
        chk("s6_rdy_seen", rdy_seen, 0);
        chk("s6_se", se_h, 32'h0);
        chk("s6_busy", busy_h, 32'h0);
        chk("s6_aborted", aborted_o, 0);

        // srst during SHIFT
        run_seq(1, 1, 8, -10, -1, -1, -1, 2, 3);
        chk("s7_snap", 64'(snap), 64'h0);
        chk("s7_done_n", done_n, 0);
        chk("s7_busy", busy_h, 32'h0006);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/scan_seq_ctl.md
Name: scan_seq_ctl

Overview:
- Parametrised on-chip scan pattern sequencer for chiptop ATPG mode. It replaces the bench-only serial pattern replay with a synthesizable controller.
- Streams load data into NCHAIN scan chains and generates the shift and capture phases.
- Compares unloaded scan-out against expected/mask data, overlapping the unload of pattern p with the load of pattern p+1.
- Sits between the test-mode register/I2C data port and the scan-inserted core; reports pass/fail and the first failure location.

Parameters:
- NCHAIN, 4, number of parallel scan chains.
- CHLEN, 32, shift cycles per load/unload (longest chain, padded).
- NCAP, 1, capture cycles per pattern (1..4).
- PATW, 12, width of pattern count and indices.
- FCW, 16, width of the saturating fail counter.

Ports:
- clk  in  1  clock; all logic rising-edge.
- srst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse, begin sequence; ignored when busy=1.
- abort  in  1  terminate sequence.
- npat  in  PATW  number of patterns, sampled on start.
- din_vld  in  1  stream beat valid.
- din_rdy  out  1  stream beat accepted when din_vld&din_rdy.
- din_si  in  NCHAIN  scan-in bits for the next pattern.
- din_exp  in  NCHAIN  expected scan-out of the previous pattern.
- din_msk  in  NCHAIN  1 = don't-care bit.
- so  in  NCHAIN  chain scan-outs.
- si  out  NCHAIN  chain scan-ins (registered).
- se  out  1  scan enable.
- sclk_en  out  1  scan clock enable (one shift per pulse).
- cap_en  out  1  capture clock enable.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  last sequence ended by abort; held until next start.
- fail_cnt  out  FCW  miscompare cycles, saturating at all-ones.
- ff_vld  out  1  a first failure is recorded.
- ff_pat  out  PATW  pattern index of first failure.
- ff_idx  out  log2(CHLEN)  shift index of first failure.

Behaviour:
- Reset values: all outputs 0, state IDLE. srst mid-sequence aborts silently with no done pulse.
- IDLE:
  - start with npat=0 -> done=1 next cycle, fail counters cleared, no beats consumed.
  - start with npat>0 -> clear fail_cnt/ff_*/aborted, pass=0, go to SHIFT.
- SHIFT:
  - se=1; din_rdy=1; sclk_en=din_vld (a stall holds all state).
  - On each accepted beat: si<=din_si; shift index increments; compare is active when pass>0.
  - Compare: mism=(so^din_exp)&~din_msk, using so sampled in the same cycle as the beat.
  - Nonzero mism -> fail_cnt+1 (saturating). If ff_vld=0, set ff_vld=1, ff_pat=pass-1, ff_idx=shift index.
- Pass exit, after CHLEN beats:
  - If pass<npat -> SETUP.
  - If pass==npat (final unload-only pass; din_si ignored, si driven 0) -> FIN.
- SETUP: 1 cycle, se=0, sclk_en=0 -> CAP.
- CAP: NCAP cycles, cap_en=1, se=0 -> HOLD.
- HOLD: 1 cycle, se=0; pass<=pass+1 -> SHIFT.
- FIN: done=1 for one cycle, busy=0 -> IDLE.
- Beat count: (npat+1)*CHLEN; exp/msk on pass 0 are ignored.
- busy=1 in every state except IDLE and FIN.
- Abort:
  - abort while busy -> next cycle IDLE, done=1, aborted=1, se/cap_en/sclk_en=0.
  - The in-cycle beat is not accepted (din_rdy=0 when abort=1).
  - Fail results are frozen.
- Simultaneous events: abort has priority over the beat and the state change; start in the same cycle as abort while busy is ignored.
- Counters: shift index wraps CHLEN-1 -> 0 at pass end; pass counter PATW bits (npat max 2^PATW-1).

Test Plan:
- NCHAIN=2, CHLEN=4, NCAP=1, npat=1, din_vld=1, msk=0, bench identity-capture chain model, correct exp -> 8 beats, SHIFT cycles 1-4 and 8-11, cap_en cycle 6, done cycle 12, fail_cnt=0, ff_vld=0.
- Same as above, chain1 bit flipped at pass-1 beat 2 -> fail_cnt=1, ff_vld=1, ff_pat=0, ff_idx=2.
- Same flip with din_msk[1]=1 on that beat -> fail_cnt=0, ff_vld=0.
- din_vld low for 3 cycles mid-pass-0 -> sclk_en low for those 3 cycles, si stable, done at cycle 15, results identical to the first scenario.
- abort asserted during CAP -> next cycle IDLE, done=1, aborted=1, se=0, cap_en=0; a following start clears aborted.
- start with npat=0 -> done next cycle, din_rdy never 1. Also: srst during SHIFT -> all outputs 0 next cycle, no done pulse.
